// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and frame format constants.
// Used by the receiver now and by the matching transmitter later.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value is a parameter so that an idle-high line does not
// look like a falling edge when reset is released.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer flops, preset to the line's idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // The second stage is the synchronized output.
  always_comb begin
    q = sync_q[1];
  end

endmodule

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver producing the ascii_char / char_valid stream,
// including NUL delimiters, for the sequence-verification automaton.
// Bits are sampled mid-bit: half a bit after the start edge, then once
// per bit period. The FSM returns to IDLE at the stop-bit sample so a
// following frame with no idle gap is caught on its start edge.
module uart_rx_ascii
  import uart_pkg::*;
#(
  parameter int UART_RX_BAUD = 20,
  parameter int freq         = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CPB = freq / UART_RX_BAUD;
  localparam int H   = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF_END = CW'(H - 1);
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_ascii: freq/UART_RX_BAUD must be at least 4");
  end

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           char_q, char_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 counting;
  logic                 sample;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Sample point: half a bit into the start bit, a full bit afterwards.
  always_comb begin
    counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    if (state_q == START) begin
      sample = (cnt_q == CNT_HALF_END);
    end else begin
      sample = counting && (cnt_q == CNT_BIT_END);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rx_s == START_BIT) state_d = START;
      START:     if (sample) state_d = (rx_s == START_BIT) ? DATA : IDLE;
      DATA:      if (sample && (bit_q == LAST_BIT)) state_d = STOP;
      STOP:      if (sample) state_d = (rx_s == STOP_BIT) ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s == STOP_BIT) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Baud counter, bit counter, shift register and result/strobe updates.
  always_comb begin
    cnt_d   = (!counting || sample) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    char_d  = char_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (state_q != DATA) begin
      bit_d = '0;
    end
    if ((state_q == DATA) && sample) begin
      shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
      bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + BW'(1);
    end
    if ((state_q == STOP) && sample) begin
      if (rx_s == STOP_BIT) begin
        char_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  // Datapath and strobe registers; reset drops any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Outputs: busy whenever a frame is being tracked.
  always_comb begin
    busy          = (state_q != IDLE);
    ascii_char    = char_q;
    char_valid    = valid_q;
    framing_error = ferr_q;
  end

endmodule

// File: doc/uart_rx_ascii.md
# uart_rx_ascii

Serial-to-parallel front end for the sequence-verification automaton: receives 8N1 UART frames on a single line at `UART_RX_BAUD` and presents each byte as `ascii_char` with a one-cycle `char_valid` strobe. It is the hardware producer of the `ascii_char`/`char_valid` stream the automaton consumes, including the NUL (0x00) delimiters that bracket each sequence. It is clocked by the system clock `freq` and shares the automaton's `clk`/`rst`.

## Interface
- `UART_RX_BAUD`, 20: line baud rate.
- `freq`, 200: `clk` frequency, same units as `UART_RX_BAUD`.
- Derived: CPB = freq/UART_RX_BAUD (integer division); H = CPB/2. CPB < 4 is an elaboration error.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `ascii_char`  out  8  last correctly framed byte; holds until the next one.
- `char_valid`  out  1  one-cycle pulse when `ascii_char` is updated.
- `framing_error`  out  1  one-cycle pulse when a stop bit is sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`; reset value of both flops is 1 (idle).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: clear bit counter and baud counter; on `rx_s`==0, go to START.
  - START: count to H-1; at the sample point, `rx_s`==0 -> DATA (baud counter cleared); `rx_s`==1 -> false start, back to IDLE, no output.
  - DATA: sample `rx_s` every CPB cycles and shift in at bit index 0..7 (LSB first). After bit 7 -> STOP.
  - STOP: sample after CPB cycles. `rx_s`==1 -> load shift register into `ascii_char`, pulse `char_valid`, go to IDLE. `rx_s`==0 -> pulse `framing_error`, leave `ascii_char` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`==1, then IDLE.
- 0x00 is a normal byte and produces `char_valid` like any other.
- Baud counter width is $clog2(CPB); it never wraps mid-bit, because it is cleared on each sample.
- Reset values: `ascii_char`=0x00, `char_valid`=0, `framing_error`=0, `busy`=0, state IDLE, shift register 0.
- Reset mid-frame: the frame is dropped immediately with no strobes, and reception restarts at the next falling edge after `rst` deasserts.

## Timing
- Cycle 0 = first rising edge where `rx_s` is 0 in IDLE (2 cycles after the raw `rx` falling edge).
- Start sample at cycle H. Data bit i is sampled at H+(i+1)*CPB. Stop bit is sampled at H+9*CPB.
- `char_valid`/`framing_error` are high for exactly the cycle after the stop sample: cycle H+9*CPB+1. Defaults (CPB=10, H=5): stop sample 95, strobe 96.
- FSM returns to IDLE at the stop sample, half a bit before the stop bit ends. Back-to-back frames with zero idle time are received without loss.
- `char_valid` and `framing_error` are never high in the same cycle.
- `busy` rises at cycle 1 and falls at the cycle of the strobe.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, START, DATA, STOP, WAIT_IDLE), `DATA_BITS`=8, `START_BIT`=0, `STOP_BIT`=1. The future matching transmitter reuses the same package.
- One sub-module: `sync_2ff` (parameterized reset value, default 1) for the `rx` synchronizer.
- The FSM, baud counter, bit counter and shift register live in `uart_rx_ascii`.

## Test plan
- Single frame 0x41 ('A'), CPB=10 -> exactly one `char_valid` pulse 98 cycles after the raw falling edge of `rx`, with `ascii_char`=0x41; `framing_error` stays 0.
- Frames 00,'A','p','p','l','e',00 sent back-to-back with no idle bits -> 7 pulses carrying 0x00,0x41,0x70,0x70,0x6C,0x65,0x00, spaced exactly 10*CPB cycles apart.
- Low glitch on `rx` of 3 cycles (< H) -> no strobes, `busy` returns to 0, and the next valid frame 0x50 is received correctly.
- Frame 0x55 with the stop bit forced to 0 for 2 bit times -> one `framing_error` pulse, no `char_valid`, `ascii_char` keeps its previous value, and `busy` stays high until `rx` returns to 1.
- `rst` asserted during data bit 4 of frame 0x6C -> all outputs go to their reset values asynchronously with no strobe; the following frame 0x65 yields `ascii_char`=0x65.
- Parameters UART_RX_BAUD=20, freq=100 (CPB=5, H=2) -> frame 0xA5 gives its strobe at cycle 2+45+1=48 after `rx_s` falls, with value 0xA5.
